// File: rtl/key_event_array.sv
// Multi-channel push-button front end: per-channel synchroniser, counter
// debouncer, press/release edge pulses and long-press / auto-repeat events.
//
// Ports:
//   i_clk        system clock (12 MHz audio domain)
//   i_rst        asynchronous active-high reset
//   i_in         raw asynchronous key pins, one bit per channel
//   i_repeat_en  per-channel auto-repeat enable (sampled on i_clk)
//   o_level      debounced pin level (same polarity as the pin)
//   o_press      1-cycle pulse when o_level leaves IDLE_LEVEL
//   o_release    1-cycle pulse when o_level returns to IDLE_LEVEL
//   o_hold       1-cycle pulse on long-press and on every repeat
//   o_held       high while the channel is in long-press
module key_event_array #(
    parameter int   N_CH          = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   DEB_CYCLES    = 60000,
    parameter int   HOLD_CYCLES   = 6000000,
    parameter int   REPEAT_CYCLES = 1200000,
    parameter logic IDLE_LEVEL    = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_in,
    input  logic [N_CH-1:0] i_repeat_en,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_hold,
    output logic [N_CH-1:0] o_held
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                        : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    genvar g;
    for (g = 0; g < N_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DW-1:0]          r_deb_cnt;
        logic                   r_level;
        logic                   r_press;
        logic                   r_release;
        logic                   w_s;
        logic                   w_chg;
        logic                   w_press_evt;
        logic                   w_rel_evt;

        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [HW-1:0]          r_hcnt;
        logic [HW-1:0]          w_hcnt_nxt;
        logic                   r_hold;
        logic                   w_hold_nxt;

        assign w_s         = r_sync[SYNC_STAGES-1];
        // The level flips on the DEB_CYCLES-th consecutive differing edge.
        assign w_chg       = (w_s != r_level) && (r_deb_cnt == DEB_LAST);
        assign w_press_evt = w_chg && (w_s != IDLE_LEVEL);
        assign w_rel_evt   = w_chg && (w_s == IDLE_LEVEL);

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_sync    <= {SYNC_STAGES{IDLE_LEVEL}};
                r_deb_cnt <= '0;
                r_level   <= IDLE_LEVEL;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], i_in[g]};
                r_press   <= w_press_evt;
                r_release <= w_rel_evt;
                if (w_s == r_level) begin
                    r_deb_cnt <= '0;
                end else if (w_chg) begin
                    r_level   <= w_s;
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt != '1) begin
                    r_deb_cnt <= r_deb_cnt + DW'(1);
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_state <= ST_IDLE;
                r_hcnt  <= '0;
                r_hold  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_hold  <= w_hold_nxt;
            end
        end

        // Release has priority over hold/repeat; a debounce glitch never
        // reaches this logic, so the hold count survives short bounces.
        always_comb begin
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            w_hold_nxt  = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_press_evt) begin
                        w_state_nxt = ST_PRESSED;
                        w_hcnt_nxt  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (w_rel_evt) begin
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == HOLD_LAST) begin
                        w_state_nxt = ST_HELD;
                        w_hold_nxt  = 1'b1;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt != '1) begin
                        w_hcnt_nxt  = r_hcnt + HW'(1);
                    end
                end
                ST_HELD: begin
                    if (w_rel_evt) begin
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (!i_repeat_en[g]) begin
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == REP_LAST) begin
                        w_hold_nxt  = 1'b1;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt != '1) begin
                        w_hcnt_nxt  = r_hcnt + HW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end

        assign o_level[g]   = r_level;
        assign o_press[g]   = r_press;
        assign o_release[g] = r_release;
        assign o_hold[g]    = r_hold;
        assign o_held[g]    = (r_state == ST_HELD);
    end

endmodule

// File: tb/tb_key_event_array.sv
// Bench for key_event_array: directed scenarios plus random key traffic,
// all cycles compared against a time-stamp based reference model.
module tb_key_event_array;

    localparam int   N  = 4;
    localparam int   SY = 2;
    localparam int   DB = 4;
    localparam int   HD = 20;
    localparam int   RP = 8;
    localparam logic IDL = 1'b1;
    localparam int   TMAX = 8192;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_v;
    logic [N-1:0] rep_v;
    logic [N-1:0] o_level, o_press, o_release, o_hold, o_held;

    key_event_array #(
        .N_CH(N), .SYNC_STAGES(SY), .DEB_CYCLES(DB),
        .HOLD_CYCLES(HD), .REPEAT_CYCLES(RP), .IDLE_LEVEL(IDL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_in(in_v), .i_repeat_en(rep_v),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_hold(o_hold), .o_held(o_held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw samples logged per edge, timestamps for events.
    int           t  = 0;
    int           rt = 0;
    logic [N-1:0] samp [0:TMAX-1];
    logic [N-1:0] e_level, e_press, e_rel, e_hold, e_held;
    bit           pressed [N];
    int           press_t [N];
    int           last_ref[N];

    task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, got, exp);
    endtask

    task automatic model_reset();
        rt      = t;
        e_level = {N{IDL}};
        e_press = '0;
        e_rel   = '0;
        e_hold  = '0;
        e_held  = '0;
        for (int c = 0; c < N; c++) begin
            pressed[c]  = 1'b0;
            press_t[c]  = 0;
            last_ref[c] = 0;
        end
    endtask

    // Synchronised value of channel c as seen by the debouncer at edge tp.
    function automatic logic s_at(int c, int tp);
        if (tp - SY > rt) return samp[tp-SY][c];
        return IDL;
    endfunction

    task automatic model_edge();
        bit chg;
        logic nl;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            chg = 1'b1;
            for (int k = 0; k < DB; k++) begin
                if (t - k <= rt) chg = 1'b0;
                else if (s_at(c, t - k) == e_level[c]) chg = 1'b0;
            end
            nl = chg ? ~e_level[c] : e_level[c];
            e_press[c] = chg && (nl != IDL);
            e_rel[c]   = chg && (nl == IDL);
            e_hold[c]  = 1'b0;
            if (e_rel[c]) begin
                pressed[c] = 1'b0;
                e_held[c]  = 1'b0;
            end else if (pressed[c] && !e_held[c]) begin
                if (t - press_t[c] == HD) begin
                    e_hold[c]   = 1'b1;
                    e_held[c]   = 1'b1;
                    last_ref[c] = t;
                end
            end else if (e_held[c]) begin
                if (!rep_v[c]) begin
                    last_ref[c] = t;
                end else if (t - last_ref[c] == RP) begin
                    e_hold[c]   = 1'b1;
                    last_ref[c] = t;
                end
            end
            if (e_press[c]) begin
                pressed[c] = 1'b1;
                press_t[c] = t;
            end
            e_level[c] = nl;
        end
    endtask

    task automatic check_all();
        chk("level",   o_level,   e_level);
        chk("press",   o_press,   e_press);
        chk("release", o_release, e_rel);
        chk("hold",    o_hold,    e_hold);
        chk("held",    o_held,    e_held);
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        if (t < TMAX) samp[t] = in_v;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst   = 1'b1;
        in_v  = '1;
        rep_v = '0;
        #1;
        model_reset();
        chk("rst_level", o_level, 4'hF);
        chk("rst_held",  o_held,  4'h0);
        idle(2);
        rst = 1'b0;
        idle(4);

        // Clean press on channel 0.
        in_v[0] = 1'b0;
        idle(5);
        chk("clean_lvl5", o_level, 4'hF);
        step();
        chk("clean_press", o_press, 4'b0001);
        chk("clean_lvl6",  o_level, 4'b1110);
        in_v[0] = 1'b1;
        idle(12);

        // Bounce rejection on channel 1.
        for (int i = 0; i < 40; i++) begin
            in_v[1] = ((i / 3) % 2) != 0;
            step();
            chk("bounce_lvl", o_level & 4'b0010, 4'b0010);
            chk("bounce_evt", (o_press | o_release) & 4'b0010, 4'b0000);
        end
        in_v[1] = 1'b1;
        idle(10);

        // Long press with and without auto-repeat on channel 2.
        for (int r = 1; r >= 0; r--) begin
            rep_v[2] = r[0];
            in_v[2]  = 1'b0;
            idle(6);
            chk("lp_press", o_press, 4'b0100);
            for (int k = 1; k <= 59; k++) begin
                step();
                if (r == 1)
                    chk("lp_hold_rep", o_hold & 4'b0100,
                        (k >= HD && (k - HD) % RP == 0) ? 4'b0100 : 4'b0000);
                else
                    chk("lp_hold_norep", o_hold & 4'b0100,
                        (k == HD) ? 4'b0100 : 4'b0000);
                chk("lp_held", o_held & 4'b0100,
                    (k >= HD) ? 4'b0100 : 4'b0000);
            end
            in_v[2] = 1'b1;
            idle(5);
            chk("lp_held_before_rel", o_held, 4'b0100);
            step();
            chk("lp_release", o_release, 4'b0100);
            chk("lp_held_drop", o_held, 4'b0000);
            idle(6);
        end

        // Simultaneous presses on channels 0 and 3.
        in_v[0] = 1'b0;
        in_v[3] = 1'b0;
        idle(5);
        step();
        chk("simul_press", o_press, 4'b1001);
        in_v[0] = 1'b1;
        in_v[3] = 1'b1;
        idle(12);

        // Asynchronous reset while channel 2 is held.
        rep_v[2] = 1'b1;
        in_v[2]  = 1'b0;
        idle(6 + 25);
        chk("pre_rst_held", o_held, 4'b0100);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_lvl",  o_level, 4'hF);
        chk("async_rst_held", o_held,  4'h0);
        idle(2);
        rst = 1'b0;
        idle(5);
        step();
        chk("rst_repress", o_press, 4'b0100);
        for (int k = 1; k <= HD; k++) begin
            step();
            chk("rst_hold", o_hold & 4'b0100,
                (k == HD) ? 4'b0100 : 4'b0000);
        end
        in_v[2] = 1'b1;
        idle(12);

        // Random traffic: bouncy phase, then slow phase with long holds.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, (i < 500) ? 5 : 39) == 0)
                    in_v[c] = ~in_v[c];
                if ($urandom_range(0, 39) == 0)
                    rep_v[c] = ~rep_v[c];
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
